commit_trace_buffer: RTL and testbench

COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

---
 rtl/commit_trace_pkg.sv | 21 ++
 rtl/commit_trace_buffer_if.sv | 47 ++++
 rtl/commit_compactor.sv | 30 +++
 rtl/commit_trace_buffer.sv | 107 ++++++++++
 tb/tb_commit_trace_buffer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/commit_trace_pkg.sv
// Shared definitions for the commit trace buffer.
//   XLEN_DEF, NCH_DEF, DEPTH_DEF : default width, lanes per cycle, entries
//   commit_rec_t                 : one stored trace record (lane commit or event)
package commit_trace_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NCH_DEF   = 2;
  localparam int DEPTH_DEF = 16;

  // Storage record. Event records carry the trap PC in pc and the cause in
  // cause; their rd and rd_data are zero. Lane records carry cause = 0.
  typedef struct packed {
    logic                is_event;
    logic [XLEN_DEF-1:0] cause;
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] inst;
    logic [XLEN_DEF-1:0] rd_data;
    logic [4:0]          rd;
  } commit_rec_t;

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Producer/checker bus of the commit trace buffer.
//   in_*  / ev_* : per-lane commits and trap event from the core (master drives)
//   in_ready     : buffer has room for a full cycle of records
//   out_*        : head record toward the checker, out_valid/out_ready handshake
// Handshake: the producer may present records only while in_ready=1; records
// presented while in_ready=0 are dropped. A head record transfers on every
// clock edge where out_valid && out_ready; out_* hold while out_ready=0.
interface commit_trace_buffer_if
  import commit_trace_pkg::*;
#(
  parameter int NCH  = NCH_DEF,
  parameter int XLEN = XLEN_DEF
);
  logic [NCH-1:0]      in_valid;
  logic [NCH*XLEN-1:0] in_pc;
  logic [NCH*XLEN-1:0] in_inst;
  logic [NCH*5-1:0]    in_rd;
  logic [NCH*XLEN-1:0] in_rd_data;
  logic                ev_valid;
  logic [XLEN-1:0]     ev_cause;
  logic [XLEN-1:0]     ev_pc;
  logic                in_ready;

  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     out_pc;
  logic [XLEN-1:0]     out_inst;
  logic [XLEN-1:0]     out_rd_data;
  logic [XLEN-1:0]     out_cause;
  logic [4:0]          out_rd;
  logic                out_is_event;
  logic [31:0]         out_seq;

  modport master (
    output in_valid, in_pc, in_inst, in_rd, in_rd_data, ev_valid, ev_cause, ev_pc,
    output out_ready,
    input  in_ready, out_valid, out_pc, out_inst, out_rd_data, out_cause, out_rd,
    input  out_is_event, out_seq
  );

  modport slave (
    input  in_valid, in_pc, in_inst, in_rd, in_rd_data, ev_valid, ev_cause, ev_pc,
    input  out_ready,
    output in_ready, out_valid, out_pc, out_inst, out_rd_data, out_cause, out_rd,
    output out_is_event, out_seq
  );
endinterface

// File: rtl/commit_compactor.sv
// Lane compaction for the commit trace buffer (purely combinational).
//   in_valid : per-lane commit valid (holes allowed)
//   ev_valid : trap event present this cycle
//   lane_off : write offset of each lane relative to the write pointer
//   ev_off   : write offset of the event record (after all valid lanes)
//   enq_n    : total records presented this cycle
module commit_compactor #(
  parameter int NCH = 2,
  parameter int OW  = 2
) (
  input  logic [NCH-1:0]         in_valid,
  input  logic                   ev_valid,
  output logic [NCH-1:0][OW-1:0] lane_off,
  output logic [OW-1:0]          ev_off,
  output logic [OW-1:0]          enq_n
);
  logic [OW-1:0] run;

  // Exclusive prefix count: each lane lands just after the valid lanes below it.
  always_comb begin
    run      = '0;
    lane_off = '0;
    for (int i = 0; i < NCH; i++) begin
      lane_off[i] = run;
      run         = run + OW'(in_valid[i]);
    end
    ev_off = run;
    enq_n  = run + OW'(ev_valid);
  end
endmodule

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: collects up to NCH committed instructions plus one trap
// event per cycle, stores them in order, and hands them one at a time to a
// checker with a sequence number.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus          : producer/checker handshake bus (slave side)
//   count        : current occupancy
//   overflow_err : sticky, set when records arrive while in_ready=0
module commit_trace_buffer
  import commit_trace_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int XLEN  = XLEN_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  commit_trace_buffer_if.slave     bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(NCH + 2);

  commit_rec_t mem [DEPTH];

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [31:0]           seq_q;
  logic [NCH-1:0][OW-1:0] lane_off;
  logic [OW-1:0]         ev_off;
  logic [OW-1:0]         enq_n;
  logic [CW-1:0]         free_n;
  logic [CW-1:0]         enq_acc;
  logic                  any_req;
  logic                  deq;
  commit_rec_t           lane_rec [NCH];
  commit_rec_t           ev_rec;
  commit_rec_t           head;

  commit_compactor #(.NCH(NCH), .OW(OW)) u_compactor (
    .in_valid (bus.in_valid),
    .ev_valid (bus.ev_valid),
    .lane_off (lane_off),
    .ev_off   (ev_off),
    .enq_n    (enq_n)
  );

  // Room is judged against a worst-case cycle, so acceptance never depends on
  // how many lanes happen to be valid.
  assign free_n       = CW'(DEPTH) - count;
  assign bus.in_ready = free_n >= CW'(NCH + 1);
  assign any_req      = (|bus.in_valid) | bus.ev_valid;
  assign enq_acc      = bus.in_ready ? CW'(enq_n) : '0;
  assign deq          = bus.out_valid & bus.out_ready;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      lane_rec[i]         = '0;
      lane_rec[i].pc      = bus.in_pc[i*XLEN +: XLEN];
      lane_rec[i].inst    = bus.in_inst[i*XLEN +: XLEN];
      lane_rec[i].rd      = bus.in_rd[i*5 +: 5];
      lane_rec[i].rd_data = bus.in_rd_data[i*XLEN +: XLEN];
    end
    ev_rec          = '0;
    ev_rec.is_event = 1'b1;
    ev_rec.pc       = bus.ev_pc;
    ev_rec.cause    = bus.ev_cause;
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clock) begin
    if (bus.in_ready) begin
      for (int i = 0; i < NCH; i++) begin
        if (bus.in_valid[i]) mem[wr_ptr + AW'(lane_off[i])] <= lane_rec[i];
      end
      if (bus.ev_valid) mem[wr_ptr + AW'(ev_off)] <= ev_rec;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      seq_q        <= '0;
      overflow_err <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(enq_acc);
      rd_ptr <= rd_ptr + AW'(deq);
      count  <= count + enq_acc - CW'(deq);
      if (deq) seq_q <= seq_q + 32'd1;
      if (!bus.in_ready && any_req) overflow_err <= 1'b1;
    end
  end

  // First-word fall-through from storage: head is whatever rd_ptr addresses.
  assign head             = mem[rd_ptr];
  assign bus.out_valid    = (count != '0);
  assign bus.out_pc       = head.pc;
  assign bus.out_inst     = head.inst;
  assign bus.out_rd_data  = head.rd_data;
  assign bus.out_cause    = head.cause;
  assign bus.out_rd       = head.rd;
  assign bus.out_is_event = head.is_event;
  assign bus.out_seq      = seq_q;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer (NCH=2, DEPTH=8, XLEN=32).
module tb_commit_trace_buffer;
  import commit_trace_pkg::*;

  localparam int NCH   = 2;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int W     = 1 + 4 * XLEN + 5;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  commit_trace_buffer_if #(.NCH(NCH), .XLEN(XLEN)) bus ();
  logic [CW-1:0] count;
  logic          overflow_err;

  commit_trace_buffer #(.NCH(NCH), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .count        (count),
    .overflow_err (overflow_err)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int unsigned  exp_seq;
  bit           exp_ovf;
  int           n_cmp = 0;
  int           n_bad = 0;

  function automatic logic [W-1:0] pack_rec(bit ev, logic [31:0] cause, logic [4:0] rd,
                                            logic [31:0] rd_data, logic [31:0] inst,
                                            logic [31:0] pc);
    return {ev, cause, pc, inst, rd_data, rd};
  endfunction

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.in_valid   = '0;
    bus.in_pc      = '0;
    bus.in_inst    = '0;
    bus.in_rd      = '0;
    bus.in_rd_data = '0;
    bus.ev_valid   = 1'b0;
    bus.ev_cause   = '0;
    bus.ev_pc      = '0;
    bus.out_ready  = 1'b0;
  endtask

  task automatic drive(input logic [NCH-1:0] v, input bit ev, input logic [31:0] cause,
                       input bit rdy);
    bus.in_valid = v;
    for (int i = 0; i < NCH; i++) begin
      bus.in_pc[i*XLEN +: XLEN]      = $urandom;
      bus.in_inst[i*XLEN +: XLEN]    = $urandom;
      bus.in_rd[i*5 +: 5]            = 5'($urandom_range(0, 31));
      bus.in_rd_data[i*XLEN +: XLEN] = $urandom;
    end
    bus.ev_valid  = ev;
    bus.ev_cause  = cause;
    bus.ev_pc     = $urandom;
    bus.out_ready = rdy;
  endtask

  // Called at a falling edge with inputs already driven: checks what is
  // visible now, lets one rising edge pass, then applies the queue-level rules.
  task automatic step();
    bit           ready_exp;
    logic [W-1:0] head;
    ready_exp = (DEPTH - exp_q.size()) >= (NCH + 1);
    check("in_ready", bus.in_ready, ready_exp);
    check("out_valid", bus.out_valid, exp_q.size() != 0);
    check("count", count, exp_q.size());
    check("overflow_err", overflow_err, exp_ovf);
    if (exp_q.size() != 0) begin
      head = {bus.out_is_event, bus.out_cause, bus.out_pc, bus.out_inst,
              bus.out_rd_data, bus.out_rd};
      check("head_record", head, exp_q[0]);
      check("out_seq", bus.out_seq, exp_seq);
    end
    @(posedge clock);
    if (exp_q.size() != 0 && bus.out_ready) begin
      void'(exp_q.pop_front());
      exp_seq++;
    end
    if (ready_exp) begin
      for (int i = 0; i < NCH; i++)
        if (bus.in_valid[i])
          exp_q.push_back(pack_rec(1'b0, 32'd0, bus.in_rd[i*5 +: 5],
                                   bus.in_rd_data[i*XLEN +: XLEN],
                                   bus.in_inst[i*XLEN +: XLEN], bus.in_pc[i*XLEN +: XLEN]));
      if (bus.ev_valid)
        exp_q.push_back(pack_rec(1'b1, bus.ev_cause, 5'd0, 32'd0, 32'd0, bus.ev_pc));
    end else if ((|bus.in_valid) || bus.ev_valid) begin
      exp_ovf = 1'b1;
    end
    @(negedge clock);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    idle_inputs();
    #2 reset = 1'b1;
    #1;
    check("rst_count", count, 0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_overflow", overflow_err, 1'b0);
    check("rst_out_seq", bus.out_seq, 0);
    exp_q.delete();
    exp_seq = 0;
    exp_ovf = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      drive('0, 1'b0, 32'd0, 1'b1);
      step();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    exp_seq = 0;
    exp_ovf = 1'b0;
    @(negedge clock);
    do_reset();

    // Single upper-lane commit.
    drive(2'b10, 1'b0, 32'd0, 1'b0);
    bus.in_pc[XLEN +: XLEN] = 32'h8000_0004;
    step();
    check("lane1_pc", bus.out_pc, 32'h8000_0004);
    drain(2);

    // Two lanes plus an event in one cycle.
    do_reset();
    drive(2'b11, 1'b1, 32'd2, 1'b0);
    step();
    check("three_records", count, 3);
    drain(4);

    // Fill to the in_ready threshold, then overflow.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 1'b0, 32'd0, 1'b0);
      step();
    end
    drive(2'b11, 1'b0, 32'd0, 1'b0);
    step();
    drive(2'b01, 1'b1, 32'd7, 1'b0);
    step();
    check("ovf_count_held", count, 6);
    drain(7);

    // Enqueue 2 and dequeue 1 at count=5.
    do_reset();
    drive(2'b11, 1'b0, 32'd0, 1'b0); step();
    drive(2'b11, 1'b0, 32'd0, 1'b0); step();
    drive(2'b01, 1'b0, 32'd0, 1'b0); step();
    drive(2'b11, 1'b0, 32'd0, 1'b1); step();
    check("enq2_deq1", count, 6);
    drain(7);

    // Reset in the middle of a stall, then the next record starts at seq 0.
    do_reset();
    drive(2'b11, 1'b0, 32'd0, 1'b0); step();
    drive(2'b11, 1'b0, 32'd0, 1'b0); step();
    do_reset();
    drive(2'b01, 1'b0, 32'd0, 1'b0); step();
    drain(2);

    // Well-behaved producer: 20+ records through the ring with random back-pressure.
    do_reset();
    for (int n = 0; n < 20; ) begin
      if ((DEPTH - exp_q.size()) >= (NCH + 1)) begin
        drive(2'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0), $urandom_range(0, 15),
              bit'($urandom_range(0, 1)));
        n += $countones(bus.in_valid) + int'(bus.ev_valid);
      end else begin
        drive('0, 1'b0, 32'd0, bit'($urandom_range(0, 1)));
      end
      step();
    end
    drain(DEPTH + 2);
    check("seq_after_20", bus.out_seq, exp_seq);

    // Unconstrained traffic including overflows.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive(2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), $urandom,
            bit'($urandom_range(0, 1)));
      step();
    end
    drain(DEPTH + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
